// File: rtl/calc2_pkg.sv
// Shared codes and state types for the calc2 multi-port calculator core.
package calc2_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    typedef enum logic [0:0] {
        PORT_IDLE     = 1'b0,
        PORT_WAIT_OP2 = 1'b1
    } port_state_e;

    // Queued command record for the default widths; modules re-declare it locally
    // with their own DATA_W/TAG_W so that overridden parameters stay consistent.
    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [1:0]       tag;
        logic [31:0]      op1;
        logic [31:0]      op2;
    } calc2_cmd_t;

endpackage

// File: rtl/calc2_port_fifo.sv
// One requester port: two-beat command capture FSM feeding a command FIFO.
module calc2_port_fifo
    import calc2_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] data,
    input  logic [TAG_W-1:0]  tag,
    input  logic              pop,
    output logic              ready,
    output logic              not_empty_c,
    output logic [CMD_W-1:0]  head_cmd_c,
    output logic [TAG_W-1:0]  head_tag_c,
    output logic [DATA_W-1:0] head_op1_c,
    output logic [DATA_W-1:0] head_op2_c
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } cmd_rec_t;

    port_state_e       state_q, state_n;
    logic [CMD_W-1:0]  cmd_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] op1_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              latch_c, push_c, pop_c, ready_n;
    cmd_rec_t          mem [FIFO_DEPTH];
    cmd_rec_t          head;

    // Next state; ready is registered from next state/count so it reads the registered count.
    always_comb begin
        state_n = state_q;
        latch_c = 1'b0;
        push_c  = 1'b0;
        case (state_q)
            PORT_IDLE: begin
                if (ready && cmd != CMD_NOP) begin
                    latch_c = 1'b1;
                    state_n = PORT_WAIT_OP2;
                end
            end
            PORT_WAIT_OP2: begin
                push_c  = 1'b1;
                state_n = PORT_IDLE;
            end
            default: state_n = PORT_IDLE;
        endcase
        pop_c   = pop && (count_q != '0);
        count_n = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        ready_n = (state_n == PORT_IDLE) && (count_n < CNT_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= PORT_IDLE;
            cmd_q    <= '0;
            tag_q    <= '0;
            op1_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready    <= 1'b0;
        end else begin
            state_q <= state_n;
            count_q <= count_n;
            ready   <= ready_n;
            if (latch_c) begin
                cmd_q <= cmd;
                tag_q <= tag;
                op1_q <= data;
            end
            if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the count alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr_q] <= '{cmd: cmd_q, tag: tag_q, op1: op1_q, op2: data};
        end
    end

    assign head        = mem[rd_ptr_q];
    assign not_empty_c = (count_q != '0);
    assign head_cmd_c  = head.cmd;
    assign head_tag_c  = head.tag;
    assign head_op1_c  = head.op1;
    assign head_op2_c  = head.op2;

endmodule

// File: rtl/calc2_param_core.sv
// Multi-port calculator core: per-port command FIFOs, round-robin arbiter, shared ALU,
// registered per-port response lanes.
module calc2_param_core
    import calc2_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          c_clk,
    input  logic                          reset_n,
    input  logic [NUM_PORTS*CMD_W-1:0]    req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data_in,
    input  logic [NUM_PORTS*TAG_W-1:0]    req_tag_in,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS*RESP_W-1:0]   out_resp,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [NUM_PORTS*TAG_W-1:0]    out_tag
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned SH_W  = $clog2(DATA_W);

    logic [NUM_PORTS-1:0] not_empty;
    logic [NUM_PORTS-1:0] pop;
    logic [CMD_W-1:0]     head_cmd [NUM_PORTS];
    logic [TAG_W-1:0]     head_tag [NUM_PORTS];
    logic [DATA_W-1:0]    head_op1 [NUM_PORTS];
    logic [DATA_W-1:0]    head_op2 [NUM_PORTS];

    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     grant_idx, scan_idx;
    logic                 grant_valid;

    logic [CMD_W-1:0]     sel_cmd;
    logic [TAG_W-1:0]     sel_tag;
    logic [DATA_W-1:0]    sel_op1, sel_op2;
    logic [DATA_W:0]      sum;
    logic [RESP_W-1:0]    alu_resp;
    logic [DATA_W-1:0]    alu_data;

    for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_port
        calc2_port_fifo #(
            .DATA_W     (DATA_W),
            .TAG_W      (TAG_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (c_clk),
            .rst_n       (reset_n),
            .cmd         (req_cmd_in[g*CMD_W +: CMD_W]),
            .data        (req_data_in[g*DATA_W +: DATA_W]),
            .tag         (req_tag_in[g*TAG_W +: TAG_W]),
            .pop         (pop[g]),
            .ready       (req_ready[g]),
            .not_empty_c (not_empty[g]),
            .head_cmd_c  (head_cmd[g]),
            .head_tag_c  (head_tag[g]),
            .head_op1_c  (head_op1[g]),
            .head_op2_c  (head_op2[g])
        );
        assign pop[g] = grant_valid && (grant_idx == PTR_W'(g));
    end

    // Round-robin: first non-empty FIFO at or after the pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % int'(NUM_PORTS));
            if (!grant_valid && not_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign sel_cmd = head_cmd[grant_idx];
    assign sel_tag = head_tag[grant_idx];
    assign sel_op1 = head_op1[grant_idx];
    assign sel_op2 = head_op2[grant_idx];

    // Shared ALU; every error forces the data to zero.
    always_comb begin
        alu_resp = RESP_ERR;
        alu_data = '0;
        sum      = {1'b0, sel_op1} + {1'b0, sel_op2};
        case (sel_cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (sel_op2 <= sel_op1) begin
                    alu_resp = RESP_OK;
                    alu_data = sel_op1 - sel_op2;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = sel_op1 << sel_op2[SH_W-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = sel_op1 >> sel_op2[SH_W-1:0];
            end
            default: ;
        endcase
    end

    // Response lanes are single-cycle pulses on the granted port only.
    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            if (grant_valid) begin
                out_resp[int'(grant_idx)*RESP_W +: RESP_W] <= alu_resp;
                out_data[int'(grant_idx)*DATA_W +: DATA_W] <= alu_data;
                out_tag[int'(grant_idx)*TAG_W +: TAG_W]    <= sel_tag;
                rr_ptr_q <= PTR_W'((int'(grant_idx) + 1) % int'(NUM_PORTS));
            end
        end
    end

endmodule

// File: tb/tb_calc2_param_core.sv
// Self-checking bench for calc2_param_core: scoreboard of per-port expected responses.
module tb_calc2_param_core;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TW = 2;

    logic              c_clk = 1'b0;
    logic              reset_n;
    logic [NP*4-1:0]   req_cmd_in;
    logic [NP*DW-1:0]  req_data_in;
    logic [NP*TW-1:0]  req_tag_in;
    logic [NP-1:0]     req_ready;
    logic [NP*2-1:0]   out_resp;
    logic [NP*DW-1:0]  out_data;
    logic [NP*TW-1:0]  out_tag;

    calc2_param_core #(
        .NUM_PORTS (NP), .DATA_W (DW), .TAG_W (TW), .FIFO_DEPTH (4)
    ) dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .req_ready   (req_ready),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_t;

    typedef struct {
        int          port;
        int          cyc;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        logic [7:0]  all_resp;
    } done_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    bit     mon_en  = 1'b0;
    exp_t   sb[$];
    done_t  done_q[$];

    always @(posedge c_clk) cyc <= cyc + 1;

    // Reference behaviour: returns {resp, data}.
    function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        case (cmd)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                if (s[32]) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: begin
                if (b > a) return {2'd2, 32'd0};
                return {2'd1, a - b};
            end
            4'd5: return {2'd1, a << b[4:0]};
            4'd6: return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Monitor: every response is matched in order against its port's expectations.
    always @(negedge c_clk) begin
        if (mon_en) begin
            for (int p = 0; p < NP; p++) begin
                logic [1:0]  r;
                logic [31:0] d;
                logic [1:0]  t;
                int          hit;
                r = out_resp[2*p +: 2];
                d = out_data[32*p +: 32];
                t = out_tag[2*p +: 2];
                if (r !== 2'd0) begin
                    done_q.push_back('{p, cyc, r, d, t, out_resp});
                    n_tests++;
                    hit = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (hit < 0 && sb[i].port == p) hit = i;
                    if (hit < 0) begin
                        n_fail++;
                        $display("FAIL unexpected_resp port %0d cyc %0d: got resp=%0d data=%h tag=%0d, required no response",
                                 p, cyc, r, d, t);
                    end else begin
                        if (r !== sb[hit].resp || d !== sb[hit].data || t !== sb[hit].tag) begin
                            n_fail++;
                            $display("FAIL scoreboard port %0d cyc %0d: got resp=%0d data=%h tag=%0d, required resp=%0d data=%h tag=%0d",
                                     p, cyc, r, d, t, sb[hit].resp, sb[hit].data, sb[hit].tag);
                        end
                        sb.delete(hit);
                    end
                end else if (d !== 32'd0 || t !== 2'd0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL idle_lane port %0d cyc %0d: got data=%h tag=%0d, required 0 and 0", p, cyc, d, t);
                end
            end
        end
    end

    task automatic clear_inputs();
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
    endtask

    task automatic issue_one(input int p, input logic [3:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] tag, output int n);
        int          w;
        logic [33:0] m;
        w = 0;
        @(posedge c_clk); #1;
        while (req_ready[p] !== 1'b1 && w < 50) begin
            @(posedge c_clk); #1;
            w++;
        end
        if (req_ready[p] !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout port %0d: got ready=%b, required 1", p, req_ready[p]);
            n = -100;
            return;
        end
        req_cmd_in[4*p +: 4]   = cmd;
        req_data_in[32*p +: 32] = a;
        req_tag_in[2*p +: 2]   = tag;
        @(posedge c_clk); #1;
        req_cmd_in[4*p +: 4]   = 4'd0;
        req_data_in[32*p +: 32] = b;
        n = cyc;
        m = model(cmd, a, b);
        sb.push_back('{p, m[33:32], m[31:0], tag});
        @(posedge c_clk); #1;
        clear_inputs();
    endtask

    task automatic wait_resp(input int p, output done_t e, output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge c_clk); #1;
            for (int i = 0; i < done_q.size(); i++) begin
                if (!ok && done_q[i].port == p) begin
                    e  = done_q[i];
                    ok = 1'b1;
                    done_q.delete(i);
                end
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout port %0d: got no response in 40 cycles, required one", p);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge c_clk);
        #1;
        n_tests++;
        if (out_resp !== '0 || out_data !== '0 || out_tag !== '0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got resp=%h data=%h tag=%h ready=%b, required all 0",
                     out_resp, out_data, out_tag, req_ready);
        end
        reset_n = 1'b1;
        @(negedge c_clk);
        n_tests++;
        if (req_ready !== 4'h0) begin
            n_fail++;
            $display("FAIL ready_release_early: got %b, required 0000", req_ready);
        end
        @(negedge c_clk);
        n_tests++;
        if (req_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b, required 1111", req_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_add();
        int    n;
        done_t e;
        bit    ok;
        done_q.delete();
        issue_one(0, 4'd1, 32'h1, 32'h1FFF_FFFF, 2'd2, n);
        wait_resp(0, e, ok);
        if (ok) begin
            n_tests++;
            if (e.cyc !== n + 2 || e.resp !== 2'd1 || e.data !== 32'h2000_0000 || e.tag !== 2'd2 || e.all_resp !== 8'h01) begin
                n_fail++;
                $display("FAIL single_add: got cyc=%0d resp=%0d data=%h tag=%0d lanes=%h, required cyc=%0d resp=1 data=20000000 tag=2 lanes=01",
                         e.cyc, e.resp, e.data, e.tag, e.all_resp, n + 2);
            end
            @(negedge c_clk); #1;
            n_tests++;
            if (out_resp !== 8'h00) begin
                n_fail++;
                $display("FAIL single_cycle_pulse: got resp lanes=%h, required 00", out_resp);
            end
        end
    endtask

    task automatic test_ops();
        logic [3:0]  cm [5] = '{4'd1, 4'd2, 4'd2, 4'd5, 4'd6};
        logic [31:0] a  [5] = '{32'hFFFF_FFFF, 32'h1, 32'hF, 32'h1, 32'h8000_0000};
        logic [31:0] b  [5] = '{32'h1, 32'hF, 32'h1, 32'd31, 32'h21};
        logic [1:0]  er [5] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
        logic [31:0] ed [5] = '{32'h0, 32'h0, 32'hE, 32'h8000_0000, 32'h4000_0000};
        int    n;
        done_t e;
        bit    ok;
        for (int i = 0; i < 5; i++) begin
            done_q.delete();
            issue_one(0, cm[i], a[i], b[i], 2'(i), n);
            wait_resp(0, e, ok);
            if (ok) begin
                n_tests++;
                if (e.resp !== er[i] || e.data !== ed[i] || e.tag !== 2'(i)) begin
                    n_fail++;
                    $display("FAIL op_%0d cmd %0d: got resp=%0d data=%h tag=%0d, required resp=%0d data=%h tag=%0d",
                             i, cm[i], e.resp, e.data, e.tag, er[i], ed[i], i);
                end
            end
        end
    endtask

    task automatic test_bad_cmds();
        logic [3:0] cm [4] = '{4'd3, 4'd4, 4'd7, 4'd15};
        int    n;
        done_t e;
        bit    ok;
        for (int i = 0; i < 4; i++) begin
            done_q.delete();
            issue_one(2, cm[i], 32'h55, 32'h3, 2'(i), n);
            wait_resp(2, e, ok);
            if (ok) begin
                n_tests++;
                if (e.resp !== 2'd2 || e.data !== 32'd0 || e.tag !== 2'(i)) begin
                    n_fail++;
                    $display("FAIL bad_cmd %0d: got resp=%0d data=%h tag=%0d, required resp=2 data=0 tag=%0d",
                             cm[i], e.resp, e.data, e.tag, i);
                end
            end
        end
    endtask

    task automatic test_rr(input int pre, input int start);
        int          n, w;
        done_t       e;
        bit          ok;
        logic [33:0] m;
        done_q.delete();
        issue_one(pre, 4'd1, 32'd5, 32'd6, 2'd1, n);
        wait_resp(pre, e, ok);
        @(posedge c_clk); #1;
        w = 0;
        while (req_ready !== 4'hF && w < 20) begin
            @(posedge c_clk); #1;
            w++;
        end
        for (int p = 0; p < NP; p++) begin
            req_cmd_in[4*p +: 4]    = 4'd1;
            req_data_in[32*p +: 32] = 32'(p * 16);
            req_tag_in[2*p +: 2]    = 2'(p);
        end
        @(posedge c_clk); #1;
        n = cyc;
        for (int p = 0; p < NP; p++) begin
            req_cmd_in[4*p +: 4]    = 4'd0;
            req_data_in[32*p +: 32] = 32'(p + 1);
            m = model(4'd1, 32'(p * 16), 32'(p + 1));
            sb.push_back('{p, m[33:32], m[31:0], 2'(p)});
        end
        @(posedge c_clk); #1;
        clear_inputs();
        w = 0;
        while (done_q.size() < NP && w < 20) begin
            @(negedge c_clk); #1;
            w++;
        end
        n_tests++;
        if (done_q.size() < NP) begin
            n_fail++;
            $display("FAIL rr_count start %0d: got %0d completions, required %0d", start, done_q.size(), NP);
        end else begin
            for (int i = 0; i < NP; i++) begin
                n_tests++;
                if (done_q[i].port !== (start + i) % NP || done_q[i].cyc !== n + 2 + i) begin
                    n_fail++;
                    $display("FAIL rr_order start %0d slot %0d: got port %0d cyc %0d, required port %0d cyc %0d",
                             start, i, done_q[i].port, done_q[i].cyc, (start + i) % NP, n + 2 + i);
                end
            end
        end
    endtask

    // All ports issue adds continuously; a command driven while ready is low is dropped.
    task automatic stream(input int cycles, input int reset_at, output bit saw_full);
        int          phase [NP];
        int          tagc  [NP];
        logic [1:0]  tg    [NP];
        logic [31:0] o1    [NP];
        logic [31:0] v;
        logic [33:0] m;
        saw_full = 1'b0;
        for (int p = 0; p < NP; p++) begin
            phase[p] = 0;
            tagc[p]  = 0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(posedge c_clk); #1;
            if (c == reset_at) begin
                reset_n = 1'b0;
                clear_inputs();
                return;
            end
            for (int p = 0; p < NP; p++) begin
                if (phase[p] == 1) begin
                    v = $urandom;
                    req_cmd_in[4*p +: 4]    = 4'd2;
                    req_data_in[32*p +: 32] = v;
                    m = model(4'd1, o1[p], v);
                    sb.push_back('{p, m[33:32], m[31:0], tg[p]});
                    phase[p] = 0;
                end else if (c < cycles - 1) begin
                    v = $urandom;
                    req_cmd_in[4*p +: 4]    = 4'd1;
                    req_data_in[32*p +: 32] = v;
                    req_tag_in[2*p +: 2]    = 2'(tagc[p]);
                    if (req_ready[p] === 1'b1) begin
                        phase[p] = 1;
                        o1[p]    = v;
                        tg[p]    = 2'(tagc[p]);
                        tagc[p]  = (tagc[p] + 1) % 4;
                    end else begin
                        saw_full = 1'b1;
                    end
                end else begin
                    req_cmd_in[4*p +: 4] = 4'd0;
                end
            end
        end
        @(posedge c_clk); #1;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        bit sf;
        int w;
        done_q.delete();
        stream(60, -1, sf);
        n_tests++;
        if (sf !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_backpressure: got saw_full=%0d, required 1", sf);
        end
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge c_clk); #1;
            w++;
        end
        repeat (5) @(negedge c_clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bit    sf;
        int    n;
        done_t e;
        bit    ok;
        stream(40, 20, sf);
        @(posedge c_clk); #1;
        reset_n = 1'b1;
        sb.delete();
        done_q.delete();
        @(negedge c_clk);
        n_tests++;
        if (out_resp !== '0 || out_data !== '0 || out_tag !== '0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got resp=%h data=%h tag=%h ready=%b, required all 0",
                     out_resp, out_data, out_tag, req_ready);
        end
        repeat (10) @(negedge c_clk);
        n_tests++;
        if (done_q.size() != 0 || req_ready !== 4'hF) begin
            n_fail++;
            $display("FAIL post_reset_quiet: got %0d responses ready=%b, required 0 responses ready=1111",
                     done_q.size(), req_ready);
        end
        issue_one(1, 4'd1, 32'h100, 32'h23, 2'd3, n);
        wait_resp(1, e, ok);
        if (ok) begin
            n_tests++;
            if (e.cyc !== n + 2 || e.resp !== 2'd1 || e.data !== 32'h123 || e.tag !== 2'd3) begin
                n_fail++;
                $display("FAIL fresh_add: got cyc=%0d resp=%0d data=%h tag=%0d, required cyc=%0d resp=1 data=123 tag=3",
                         e.cyc, e.resp, e.data, e.tag, n + 2);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_add();
        test_ops();
        test_bad_cmds();
        test_rr(3, 0);
        test_rr(1, 2);
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge c_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
